// File: rtl/sumres_seq.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock,
// with a registered carry rippling between digits and start/ready/done handshake.
module sumres_seq #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Ci,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf,
   output logic             Zero
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : gBadParams
      $error("sumres_seq: WIDTH must be >= 2 and an exact multiple of DIGIT");
   end

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] operandA_q, operandA_d;
   logic [WIDTH-1:0] operandBx_q, operandBx_d;
   logic [WIDTH-1:0] partial_q, partial_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    digitCnt_q, digitCnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   int unsigned      digitBase;
   logic [DIGIT-1:0] aDigit;
   logic [DIGIT-1:0] bDigit;
   logic [DIGIT:0]   digitSum;

   // Subtraction is folded into the latch: B is inverted and the borrow-in becomes ~Ci,
   // so the RUN datapath is always a plain add.
   always_comb begin
      digitBase   = int'(digitCnt_q) * DIGIT;
      aDigit      = operandA_q[digitBase +: DIGIT];
      bDigit      = operandBx_q[digitBase +: DIGIT];
      digitSum    = {1'b0, aDigit} + {1'b0, bDigit} + {{DIGIT{1'b0}}, carry_q};

      state_d     = state_q;
      operandA_d  = operandA_q;
      operandBx_d = operandBx_q;
      partial_d   = partial_q;
      carry_d     = carry_q;
      digitCnt_d  = digitCnt_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               operandA_d  = A;
               operandBx_d = op ? ~B : B;
               carry_d     = op ? ~Ci : Ci;
               partial_d   = '0;
               digitCnt_d  = '0;
               state_d     = RUN;
            end
         end
         RUN: begin
            partial_d[digitBase +: DIGIT] = digitSum[DIGIT-1:0];
            carry_d = digitSum[DIGIT];
            if (digitCnt_q == LAST_DIGIT) begin
               sum_d   = partial_d;
               cout_d  = digitSum[DIGIT];
               ovf_d   = (operandA_q[WIDTH-1] == operandBx_q[WIDTH-1]) &&
                         (partial_d[WIDTH-1] != operandA_q[WIDTH-1]);
               zero_d  = (partial_d == '0);
               state_d = DONE;
            end else begin
               digitCnt_d = digitCnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         operandA_q  <= '0;
         operandBx_q <= '0;
         partial_q   <= '0;
         carry_q     <= 1'b0;
         digitCnt_q  <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         operandA_q  <= operandA_d;
         operandBx_q <= operandBx_d;
         partial_q   <= partial_d;
         carry_q     <= carry_d;
         digitCnt_q  <= digitCnt_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
      end
   end

   assign ready = (state_q == IDLE);
   assign done  = (state_q == DONE);
   assign Sum   = sum_q;
   assign Cout  = cout_q;
   assign Ovf   = ovf_q;
   assign Zero  = zero_q;

endmodule

// File: tb/tb_sumres_seq.sv
// Scoreboard bench for sumres_seq: directed 16/4 vectors plus random 8/8 and 12/3 runs,
// with expected results queued at issue time and popped by per-instance monitors.
module tb_sumres_seq;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start16 = 1'b0, op16 = 1'b0, ci16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0, sum16;
   logic        ready16, done16, cout16, ovf16, zero16;

   logic        start8 = 1'b0, op8 = 1'b0, ci8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0, sum8;
   logic        ready8, done8, cout8, ovf8, zero8;

   logic        start12 = 1'b0, op12 = 1'b0, ci12 = 1'b0;
   logic [11:0] a12 = '0, b12 = '0, sum12;
   logic        ready12, done12, cout12, ovf12, zero12;

   sumres_seq #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .A(a16), .B(b16), .Ci(ci16),
      .ready(ready16), .done(done16), .Sum(sum16), .Cout(cout16), .Ovf(ovf16), .Zero(zero16));

   sumres_seq #(.WIDTH(8), .DIGIT(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .A(a8), .B(b8), .Ci(ci8),
      .ready(ready8), .done(done8), .Sum(sum8), .Cout(cout8), .Ovf(ovf8), .Zero(zero8));

   sumres_seq #(.WIDTH(12), .DIGIT(3)) dut12 (
      .clk(clk), .rst_n(rst_n), .start(start12), .op(op12), .A(a12), .B(b12), .Ci(ci12),
      .ready(ready12), .done(done12), .Sum(sum12), .Cout(cout12), .Ovf(ovf12), .Zero(zero12));

   int errors = 0;
   int checks = 0;

   exp_t  q16[$];
   string n16[$];
   exp_t  q8[$];
   exp_t  q12[$];

   logic [15:0] lastSum16 = '0;

   // Behavioural reference: whole-word add of A and conditionally inverted B.
   function automatic exp_t modelOp(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic op, input logic ci);
      exp_t        e;
      logic [31:0] mask;
      logic [31:0] bx;
      logic [32:0] full;
      mask   = (32'd1 << w) - 32'd1;
      bx     = op ? (~b & mask) : b;
      full   = {1'b0, a} + {1'b0, bx} + {32'd0, op ^ ci};
      e.sum  = full[31:0] & mask;
      e.cout = full[w];
      e.ovf  = (a[w-1] == bx[w-1]) && (e.sum[w-1] != a[w-1]);
      e.zero = (e.sum == 32'd0);
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   // Monitors pop the oldest outstanding expectation whenever a done pulse appears.
   always @(negedge clk) begin
      if (rst_n && done16) begin
         if (q16.size() == 0) begin
            checkOutput("dut16 unexpected done (got Sum, required none)", 64'(sum16), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            checkOutput(n16.pop_front(), 64'({16'd0, sum16, cout16, ovf16, zero16}), 64'(q16.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done8) begin
         if (q8.size() == 0) begin
            checkOutput("dut8 unexpected done (got Sum, required none)", 64'(sum8), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            checkOutput("dut8 random result", 64'({24'd0, sum8, cout8, ovf8, zero8}), 64'(q8.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done12) begin
         if (q12.size() == 0) begin
            checkOutput("dut12 unexpected done (got Sum, required none)", 64'(sum12), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            checkOutput("dut12 random result", 64'({20'd0, sum12, cout12, ovf12, zero12}), 64'(q12.pop_front()));
         end
      end
   end

   // mode 0: plain op; mode 1: start re-pulsed with new operands during RUN;
   // mode 2: operands/op/Ci changed right after the start edge.
   task automatic applyStimulus(input string name, input logic opv, input logic [15:0] av,
                                input logic [15:0] bv, input logic civ, input logic [15:0] es,
                                input logic ec, input logic eo, input logic ez, input int mode);
      int   waitCnt;
      int   lat;
      exp_t e;
      waitCnt = 0;
      while (!ready16 && waitCnt < 50) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      if (!ready16) begin
         checkOutput({name, " ready timeout"}, 64'(ready16), 64'd1);
         return;
      end
      op16 = opv; a16 = av; b16 = bv; ci16 = civ; start16 = 1'b1;
      e.sum = 32'(es); e.cout = ec; e.ovf = eo; e.zero = ez;
      q16.push_back(e);
      n16.push_back(name);
      @(posedge clk); #1;
      start16 = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (mode == 1 && lat == 1) begin
            start16 = 1'b1; a16 = 16'hDEAD; b16 = 16'hBEEF; op16 = ~opv; ci16 = ~civ;
         end
         if (mode == 1 && lat == 3) start16 = 1'b0;
         if (mode == 2 && lat == 1) begin
            a16 = ~av; b16 = ~bv; op16 = ~opv; ci16 = ~civ;
         end
         if (!done16) checkOutput({name, " Sum held during RUN"}, 64'(sum16), 64'(lastSum16));
      end while (!done16 && lat < 20);
      checkOutput({name, " done latency"}, 64'(lat), 64'd4);
      lastSum16 = es;
      @(posedge clk); #1;
      checkOutput({name, " done one cycle then ready"}, 64'({done16, ready16}), 64'b01);
   endtask

   task automatic applyMidRunReset();
      op16 = 1'b0; a16 = 16'h4321; b16 = 16'h0001; ci16 = 1'b0; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abort: reset values {ready,done,Sum,Cout,Ovf,Zero}",
                  64'({ready16, done16, sum16, cout16, ovf16, zero16}),
                  64'({1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}));
      @(negedge clk);
      rst_n = 1'b1;
      lastSum16 = '0;
      repeat (8) @(posedge clk);
      #1;
      checkOutput("abort: idle after reset {ready,Sum}", 64'({ready16, sum16}), 64'({1'b1, 16'h0000}));
   endtask

   task automatic runRandom8(input int count);
      int waitCnt;
      for (int i = 0; i < count; i++) begin
         waitCnt = 0;
         while (!ready8 && waitCnt < 50) begin
            @(posedge clk); #1;
            waitCnt++;
         end
         if (!ready8) begin
            checkOutput("dut8 ready timeout", 64'(ready8), 64'd1);
            return;
         end
         a8 = 8'($urandom); b8 = 8'($urandom); op8 = 1'($urandom); ci8 = 1'($urandom);
         q8.push_back(modelOp(8, 32'(a8), 32'(b8), op8, ci8));
         start8 = 1'b1;
         @(posedge clk); #1;
         start8 = 1'b0;
      end
   endtask

   task automatic runRandom12(input int count);
      int waitCnt;
      for (int i = 0; i < count; i++) begin
         waitCnt = 0;
         while (!ready12 && waitCnt < 50) begin
            @(posedge clk); #1;
            waitCnt++;
         end
         if (!ready12) begin
            checkOutput("dut12 ready timeout", 64'(ready12), 64'd1);
            return;
         end
         a12 = 12'($urandom); b12 = 12'($urandom); op12 = 1'($urandom); ci12 = 1'($urandom);
         q12.push_back(modelOp(12, 32'(a12), 32'(b12), op12, ci12));
         start12 = 1'b1;
         @(posedge clk); #1;
         start12 = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset values {ready,done,Sum,Cout,Ovf,Zero}",
                  64'({ready16, done16, sum16, cout16, ovf16, zero16}),
                  64'({1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      applyStimulus("add 1234+1111",      1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 0);
      applyStimulus("add FFFF+0001",      1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
      applyStimulus("add 7FFF+0001",      1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
      applyStimulus("sub 8000-0001",      1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0);
      applyStimulus("sub 0005-0007-1",    1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0, 0);
      applyStimulus("sub 0005-0005",      1'b1, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
      applyStimulus("add 0100+0020+1 start in RUN", 1'b0, 16'h0100, 16'h0020, 1'b1, 16'h0121, 1'b0, 1'b0, 1'b0, 1);
      applyStimulus("add 00FF+0001 inputs change", 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 2);
      applyMidRunReset();
      applyStimulus("add 0F0F+F0F0 after abort", 1'b0, 16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);

      runRandom8(1000);
      runRandom12(1000);
      repeat (20) @(posedge clk);
      #1;
      checkOutput("outstanding results {dut16,dut8,dut12}",
                  64'({16'(q16.size()), 16'(q8.size()), 16'(q12.size())}), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
